// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen
// Parametrised LFSR pseudo-random source for the reaction-timer family.
// The state register steps in Fibonacci or Galois form. A zero state is
// never allowed to persist. A small req/valid engine draws a value in
// [lo, hi] by rejection sampling, using a bounded number of candidates.
//
// Ports:
//   clk        rising-edge clock
//   preset     synchronous active-high reset, loads SEED and idles the engine
//   en         free-running step enable
//   load       load seed_in into the state (zero seed becomes SEED)
//   seed_in    seed value
//   req        draw request, only looked at while idle
//   lo, hi     inclusive unsigned bounds, captured when a request is taken
//   y          current LFSR state
//   rnd        last drawn value, held until the next completion
//   rnd_valid  one-cycle pulse marking a completed draw
//   busy       high while a draw is in flight (DRAW and DONE)
//   fallback   last draw returned lo instead of a sampled value
//   lockup     one-cycle pulse when a zero state was replaced by SEED
module lfsr_rand_gen #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int               MODE      = 0,
    parameter int               MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             preset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid,
    output logic             busy,
    output logic             fallback,
    output logic             lockup
);

    localparam int TW = $clog2(MAX_TRIES) + 1;
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [TW-1:0]    tries;
    logic [WIDTH-1:0] stepped;
    logic             do_step;
    logic             in_range;

    // Next LFSR value if a step is taken this cycle. Fibonacci shifts the
    // tap parity in at the top; Galois shifts right and folds the tap mask
    // back in whenever a one falls off the bottom.
    always_comb begin
        stepped = '0;
        if (MODE == 0) begin
            stepped = {^(y & TAPS), y[WIDTH-1:1]};
        end else begin
            stepped = (y >> 1) ^ (y[0] ? TAPS : '0);
        end
    end

    // The generator must keep moving while a draw is in flight so that
    // every DRAW cycle sees a fresh candidate, even with en low.
    assign do_step  = en || (state == S_DRAW);
    assign in_range = (y >= lo_q) && (y <= hi_q);

    // State register. preset wins over load, load wins over stepping.
    // A zero state can never step its way out, so both a zero load and a
    // zero state about to step are replaced by SEED and flagged on lockup.
    always_ff @(posedge clk) begin
        if (preset) begin
            y      <= SEED;
            lockup <= 1'b0;
        end else if (load) begin
            if (seed_in == '0) begin
                y      <= SEED;
                lockup <= 1'b1;
            end else begin
                y      <= seed_in;
                lockup <= 1'b0;
            end
        end else if (do_step) begin
            if (y == '0) begin
                y      <= SEED;
                lockup <= 1'b1;
            end else begin
                y      <= stepped;
                lockup <= 1'b0;
            end
        end else begin
            lockup <= 1'b0;
        end
    end

    // Draw engine. IDLE takes a request and captures the bounds; DRAW
    // tests the current state as a candidate once per cycle and gives up
    // with lo after MAX_TRIES rejections; DONE pulses rnd_valid once.
    // Inverted bounds cannot be satisfied, so they skip straight to DONE
    // with the fallback value. busy and rnd_valid are registered alongside
    // the state so they line up exactly with DRAW/DONE.
    always_ff @(posedge clk) begin
        if (preset) begin
            state     <= S_IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            tries     <= '0;
            rnd       <= '0;
            rnd_valid <= 1'b0;
            busy      <= 1'b0;
            fallback  <= 1'b0;
        end else begin
            rnd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        if (lo <= hi) begin
                            lo_q  <= lo;
                            hi_q  <= hi;
                            tries <= '0;
                            state <= S_DRAW;
                        end else begin
                            rnd       <= lo;
                            fallback  <= 1'b1;
                            rnd_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DRAW: begin
                    if (in_range) begin
                        rnd       <= y;
                        fallback  <= 1'b0;
                        rnd_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (tries == LAST_TRY) begin
                        rnd       <= lo_q;
                        fallback  <= 1'b1;
                        rnd_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        tries <= tries + TW'(1);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// tb_lfsr_rand_gen
// Self-checking bench for lfsr_rand_gen. Instance A is the 5-bit legacy
// Fibonacci configuration and carries all draw-engine scenarios; instance
// B is the default 16-bit generator in Galois mode. Expected values come
// from arithmetic reference functions and from numbers worked out by hand.
module tb_lfsr_rand_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 5-bit legacy configuration
    logic       preset_a, en_a, load_a, req_a;
    logic [4:0] seed_a, lo_a, hi_a;
    logic [4:0] y_a, rnd_a;
    logic       rnd_valid_a, busy_a, fallback_a, lockup_a;

    // Instance B: 16-bit Galois
    logic        preset_b, en_b, load_b, req_b;
    logic [15:0] seed_b, lo_b, hi_b;
    logic [15:0] y_b, rnd_b;
    logic        rnd_valid_b, busy_b, fallback_b, lockup_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int my_a;
    int my_b;

    lfsr_rand_gen #(
        .WIDTH(5), .TAPS(5'b00101), .SEED(5'h1F), .MODE(0), .MAX_TRIES(8)
    ) dut_a (
        .clk(clk), .preset(preset_a), .en(en_a), .load(load_a),
        .seed_in(seed_a), .req(req_a), .lo(lo_a), .hi(hi_a),
        .y(y_a), .rnd(rnd_a), .rnd_valid(rnd_valid_a), .busy(busy_a),
        .fallback(fallback_a), .lockup(lockup_a)
    );

    lfsr_rand_gen #(
        .MODE(1)
    ) dut_b (
        .clk(clk), .preset(preset_b), .en(en_b), .load(load_b),
        .seed_in(seed_b), .req(req_b), .lo(lo_b), .hi(hi_b),
        .y(y_b), .rnd(rnd_b), .rnd_valid(rnd_valid_b), .busy(busy_b),
        .fallback(fallback_b), .lockup(lockup_b)
    );

    // Legacy rule: new top bit is the parity of the tapped bits (2 and 0),
    // the rest of the word moves down by one. Zero is replaced by the seed.
    function automatic int fib5(input int v);
        int ones;
        ones = 0;
        if (v == 0) return 'h1F;
        for (int i = 0; i < 5; i++) begin
            if ((((5 >> i) % 2) == 1) && (((v >> i) % 2) == 1)) ones++;
        end
        return ((ones % 2) * 16) + (v / 2);
    endfunction

    // Galois rule: halve, and if the value was odd fold in the tap mask.
    function automatic int gal16(input int v);
        if (v == 0) return 'hACE1;
        if ((v % 2) == 1) return (v / 2) ^ 'hB400;
        return v / 2;
    endfunction

    // Outcome of a draw starting from state ystart with en=0: candidates are
    // ystart and its successors; the first in range wins, otherwise lo after
    // eight tries. exp_y is the state once the draw has finished.
    function automatic void predict_draw(input int ystart, input int l, input int h,
                                         output int exp_rnd, output int exp_fb,
                                         output int exp_lat, output int exp_y);
        int c;
        c = ystart;
        if (l > h) begin
            exp_rnd = l; exp_fb = 1; exp_lat = 1; exp_y = ystart;
            return;
        end
        for (int k = 0; k < 8; k++) begin
            if (c >= l && c <= h) begin
                exp_rnd = c; exp_fb = 0; exp_lat = k + 2; exp_y = fib5(c);
                return;
            end
            c = fib5(c);
        end
        exp_rnd = l; exp_fb = 1; exp_lat = 9; exp_y = c;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on instance A and wait (bounded) for completion.
    // lat counts edges from the accepting edge to the one after which
    // rnd_valid is seen; a lost completion shows up as lat = 20.
    task automatic run_draw(input int l, input int h, output int lat,
                            output int busy_cycles, output int got_rnd, output int got_fb);
        lo_a  = 5'(l);
        hi_a  = 5'(h);
        req_a = 1'b1;
        cyc();
        req_a = 1'b0;
        lat = 1;
        busy_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy_a) busy_cycles++;
            if (rnd_valid_a || lat >= 20) break;
            cyc();
            lat++;
        end
        got_rnd = int'(rnd_a);
        got_fb  = int'(fallback_a);
    endtask

    task automatic test_reset();
        preset_a = 1'b1;
        preset_b = 1'b1;
        cyc();
        cyc();
        tests_run++;
        if (y_a !== 5'h1F) begin tests_failed++; $display("[TB] FAIL reset_y_a: got %0h expected 1f", y_a); end
        tests_run++;
        if (rnd_a !== 5'h00) begin tests_failed++; $display("[TB] FAIL reset_rnd: got %0h expected 0", rnd_a); end
        tests_run++;
        if ({rnd_valid_a, busy_a, fallback_a, lockup_a} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {rnd_valid_a, busy_a, fallback_a, lockup_a});
        end
        tests_run++;
        if (y_b !== 16'hACE1) begin tests_failed++; $display("[TB] FAIL reset_y_b: got %0h expected ace1", y_b); end
        preset_a = 1'b0;
        preset_b = 1'b0;
        my_a = 'h1F;
        my_b = 'hACE1;
    endtask

    task automatic test_legacy_sequence();
        int expect_seq [6] = '{'h1F, 'h0F, 'h07, 'h03, 'h11, 'h18};
        logic zero_seen;
        logic early_wrap;
        zero_seen  = 1'b0;
        early_wrap = 1'b0;
        tests_run++;
        if (y_a !== 5'(expect_seq[0])) begin tests_failed++; $display("[TB] FAIL legacy_start: got %0h expected %0h", y_a, expect_seq[0]); end
        en_a = 1'b1;
        for (int i = 1; i < 6; i++) begin
            cyc();
            my_a = fib5(my_a);
            tests_run++;
            if (y_a !== 5'(expect_seq[i])) begin
                tests_failed++;
                $display("[TB] FAIL legacy_seq[%0d]: got %0h expected %0h", i, y_a, expect_seq[i]);
            end
        end
        for (int s = 6; s <= 31; s++) begin
            cyc();
            my_a = fib5(my_a);
            if (y_a == 5'h00) zero_seen = 1'b1;
            if (s < 31 && y_a == 5'h1F) early_wrap = 1'b1;
            tests_run++;
            if (y_a !== 5'(my_a)) begin tests_failed++; $display("[TB] FAIL legacy_step[%0d]: got %0h expected %0h", s, y_a, my_a); end
        end
        en_a = 1'b0;
        tests_run++;
        if (y_a !== 5'h1F) begin tests_failed++; $display("[TB] FAIL legacy_period: got %0h expected 1f after 31 steps", y_a); end
        tests_run++;
        if (zero_seen !== 1'b0 || early_wrap !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL legacy_no_zero_or_short_cycle: got zero=%b early=%b expected 0 0", zero_seen, early_wrap);
        end
    endtask

    task automatic test_galois();
        logic exp_lock;
        en_b = 1'b1;
        cyc();
        en_b = 1'b0;
        my_b = gal16(my_b);
        tests_run++;
        if (y_b !== 16'hE270) begin tests_failed++; $display("[TB] FAIL galois_step: got %0h expected e270", y_b); end
        load_b = 1'b1;
        seed_b = 16'h0000;
        cyc();
        load_b = 1'b0;
        my_b = 'hACE1;
        tests_run++;
        if (y_b !== 16'hACE1 || lockup_b !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL galois_zero_load: got y=%0h lockup=%b expected ace1 1", y_b, lockup_b);
        end
        cyc();
        tests_run++;
        if (y_b !== 16'hACE1 || lockup_b !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL galois_lockup_pulse: got y=%0h lockup=%b expected ace1 0", y_b, lockup_b);
        end
        for (int i = 0; i < 40; i++) begin
            en_b   = 1'($urandom_range(0, 3) != 0);
            load_b = 1'($urandom_range(0, 7) == 0);
            seed_b = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
            exp_lock = 1'b0;
            if (load_b) begin
                if (seed_b == 16'h0000) begin my_b = 'hACE1; exp_lock = 1'b1; end
                else my_b = int'(seed_b);
            end else if (en_b) begin
                if (my_b == 0) exp_lock = 1'b1;
                my_b = gal16(my_b);
            end
            cyc();
            tests_run++;
            if (y_b !== 16'(my_b) || lockup_b !== exp_lock) begin
                tests_failed++;
                $display("[TB] FAIL galois_random[%0d]: got y=%0h lockup=%b expected %0h %b", i, y_b, lockup_b, my_b, exp_lock);
            end
        end
        en_b   = 1'b0;
        load_b = 1'b0;
    endtask

    task automatic test_full_range();
        int lat, bc, r, fb, er, efb, elat, ey;
        preset_a = 1'b1;
        cyc();
        preset_a = 1'b0;
        my_a = 'h1F;
        predict_draw(my_a, 0, 31, er, efb, elat, ey);
        run_draw(0, 31, lat, bc, r, fb);
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("[TB] FAIL full_range_latency: got %0d expected 2", lat); end
        tests_run++;
        if (r !== 'h1F || fb !== 0) begin tests_failed++; $display("[TB] FAIL full_range_value: got rnd=%0h fb=%0d expected 1f 0", r, fb); end
        tests_run++;
        if (bc !== 2) begin tests_failed++; $display("[TB] FAIL full_range_busy: got %0d cycles expected 2", bc); end
        cyc();
        my_a = ey;
        tests_run++;
        if (rnd_valid_a !== 1'b0 || busy_a !== 1'b0 || y_a !== 5'(my_a)) begin
            tests_failed++;
            $display("[TB] FAIL full_range_after: got valid=%b busy=%b y=%0h expected 0 0 %0h", rnd_valid_a, busy_a, y_a, my_a);
        end
    endtask

    task automatic test_unreachable();
        int lat, er, efb, elat, ey;
        predict_draw(my_a, 0, 0, er, efb, elat, ey);
        lo_a  = 5'd0;
        hi_a  = 5'd0;
        req_a = 1'b1;
        cyc();
        req_a = 1'b0;
        lat = 1;
        // A second request with a wide range arrives mid-draw; it must be
        // ignored and must not change the captured bounds.
        lo_a = 5'd0;
        hi_a = 5'd31;
        for (int k = 0; k < 20; k++) begin
            if (rnd_valid_a) break;
            req_a = (lat == 3) ? 1'b1 : 1'b0;
            cyc();
            lat++;
        end
        req_a = 1'b0;
        tests_run++;
        if (lat !== 9) begin tests_failed++; $display("[TB] FAIL unreachable_latency: got %0d expected 9", lat); end
        tests_run++;
        if (rnd_a !== 5'd0 || fallback_a !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL unreachable_value: got rnd=%0h fb=%b expected 0 1", rnd_a, fallback_a);
        end
        my_a = ey;
        for (int k = 0; k < 4; k++) begin
            cyc();
            tests_run++;
            if (rnd_valid_a !== 1'b0 || busy_a !== 1'b0 || y_a !== 5'(my_a) || fallback_a !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL unreachable_ignored_req[%0d]: got valid=%b busy=%b y=%0h fb=%b expected 0 0 %0h 1",
                         k, rnd_valid_a, busy_a, y_a, fallback_a, my_a);
            end
        end
    endtask

    task automatic test_inverted();
        int lat, bc, r, fb;
        run_draw(20, 10, lat, bc, r, fb);
        tests_run++;
        if (lat !== 1) begin tests_failed++; $display("[TB] FAIL inverted_latency: got %0d expected 1", lat); end
        tests_run++;
        if (r !== 20 || fb !== 1) begin tests_failed++; $display("[TB] FAIL inverted_value: got rnd=%0d fb=%0d expected 20 1", r, fb); end
        cyc();
        tests_run++;
        if (y_a !== 5'(my_a) || busy_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL inverted_y_held: got y=%0h busy=%b expected %0h 0", y_a, busy_a, my_a);
        end
    endtask

    task automatic test_back_to_back();
        int cand;
        logic exp_valid;
        cand  = my_a;
        lo_a  = 5'd0;
        hi_a  = 5'd31;
        req_a = 1'b1;
        cyc();
        for (int idx = 0; idx < 9; idx++) begin
            exp_valid = ((idx % 3) == 1);
            tests_run++;
            if (rnd_valid_a !== exp_valid) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back_valid[%0d]: got %b expected %b", idx, rnd_valid_a, exp_valid);
            end
            if (exp_valid) begin
                tests_run++;
                if (rnd_a !== 5'(cand)) begin
                    tests_failed++;
                    $display("[TB] FAIL back_to_back_rnd[%0d]: got %0h expected %0h", idx, rnd_a, cand);
                end
                cand = fib5(cand);
            end
            if (idx == 8) req_a = 1'b0;
            else cyc();
        end
        my_a = cand;
        cyc();
        tests_run++;
        if (busy_a !== 1'b0 || y_a !== 5'(my_a)) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_end: got busy=%b y=%0h expected 0 %0h", busy_a, y_a, my_a);
        end
    endtask

    task automatic test_reset_mid_draw();
        logic pulsed;
        pulsed = 1'b0;
        lo_a  = 5'd0;
        hi_a  = 5'd0;
        req_a = 1'b1;
        cyc();
        req_a = 1'b0;
        if (rnd_valid_a) pulsed = 1'b1;
        cyc();
        if (rnd_valid_a) pulsed = 1'b1;
        cyc();
        if (rnd_valid_a) pulsed = 1'b1;
        preset_a = 1'b1;
        cyc();
        preset_a = 1'b0;
        my_a = 'h1F;
        tests_run++;
        if (busy_a !== 1'b0 || rnd_valid_a !== 1'b0 || y_a !== 5'h1F || rnd_a !== 5'h00 || fallback_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_draw_reset: got busy=%b valid=%b y=%0h rnd=%0h fb=%b expected 0 0 1f 0 0",
                     busy_a, rnd_valid_a, y_a, rnd_a, fallback_a);
        end
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (rnd_valid_a) pulsed = 1'b1;
        end
        tests_run++;
        if (pulsed !== 1'b0 || y_a !== 5'h1F) begin
            tests_failed++;
            $display("[TB] FAIL mid_draw_no_completion: got pulsed=%b y=%0h expected 0 1f", pulsed, y_a);
        end
    endtask

    task automatic test_random_draws();
        int l, h, lat, bc, r, fb, er, efb, elat, ey, nsteps, s;
        for (int it = 0; it < 30; it++) begin
            nsteps = $urandom_range(0, 3);
            en_a = 1'b1;
            for (int k = 0; k < nsteps; k++) begin
                cyc();
                my_a = fib5(my_a);
            end
            en_a = 1'b0;
            if ($urandom_range(0, 4) == 0) begin
                s = $urandom_range(1, 31);
                seed_a = 5'(s);
                load_a = 1'b1;
                cyc();
                load_a = 1'b0;
                my_a = s;
            end
            l = $urandom_range(0, 31);
            if ($urandom_range(0, 5) == 0) h = $urandom_range(0, 31);
            else begin
                h = l + $urandom_range(0, 6);
                if (h > 31) h = 31;
            end
            predict_draw(my_a, l, h, er, efb, elat, ey);
            run_draw(l, h, lat, bc, r, fb);
            tests_run++;
            if (lat !== elat || r !== er || fb !== efb) begin
                tests_failed++;
                $display("[TB] FAIL random_draw[%0d] lo=%0d hi=%0d: got lat=%0d rnd=%0d fb=%0d expected %0d %0d %0d",
                         it, l, h, lat, r, fb, elat, er, efb);
            end
            cyc();
            my_a = ey;
            tests_run++;
            if (y_a !== 5'(my_a)) begin
                tests_failed++;
                $display("[TB] FAIL random_draw_state[%0d]: got %0h expected %0h", it, y_a, my_a);
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        preset_a = 1'b1; en_a = 1'b0; load_a = 1'b0; req_a = 1'b0;
        seed_a = '0; lo_a = '0; hi_a = '0;
        preset_b = 1'b1; en_b = 1'b0; load_b = 1'b0; req_b = 1'b0;
        seed_b = '0; lo_b = '0; hi_b = '0;
        my_a = 'h1F;
        my_b = 'hACE1;

        test_reset();
        test_legacy_sequence();
        test_galois();
        test_full_range();
        test_unreachable();
        test_inverted();
        test_back_to_back();
        test_reset_mid_draw();
        test_random_draws();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
